// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle: imem req/ack, decode valid/ready, redirect and halt status.
interface fetch_unit_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [5:0]        op;
  logic [PC_W-1:0]   inst_pc;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              halted;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, op, inst_pc, halted,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, op, inst_pc, halted,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer owning the PC, with branch redirect and halt.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HALT_OP  = 6'd63
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH, ISSUE, DRAIN, HALT} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [5:0]        op_q, op_d;

  logic [5:0]        rdata_op;
  logic [PC_W-1:0]   pc_inc;

  assign rdata_op = bus.imem_rdata[INST_W-1:INST_W-6];
  assign pc_inc   = pc_q + PC_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_pc_d = inst_pc_q;
    req_d     = req_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    inst_d    = inst_q;
    op_d      = op_q;

    unique case (state_q)
      FETCH: begin
        if (!req_q) begin
          // Only reached straight after reset or a drain; acks seen here belong to an abandoned request.
          req_d = 1'b1;
          if (bus.redirect) begin
            pc_d   = bus.redirect_pc;
            addr_d = bus.redirect_pc;
          end else begin
            addr_d = pc_q;
          end
        end else if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_ack) begin
            addr_d = bus.redirect_pc;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus.imem_ack) begin
          inst_d    = bus.imem_rdata;
          op_d      = rdata_op;
          inst_pc_d = pc_q;
          pc_d      = pc_inc;
          valid_d   = 1'b1;
          req_d     = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.redirect) begin
          valid_d = 1'b0;
          pc_d    = bus.redirect_pc;
          req_d   = 1'b1;
          addr_d  = bus.redirect_pc;
          state_d = FETCH;
        end else if (bus.inst_ready) begin
          valid_d = 1'b0;
          if (op_q == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        // The outstanding request stays on the bus at its old address; its data is dropped.
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (bus.redirect) begin
          halted_d = 1'b0;
          pc_d     = bus.redirect_pc;
          req_d    = 1'b1;
          addr_d   = bus.redirect_pc;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      inst_pc_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      inst_q    <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_pc_q <= inst_pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      inst_q    <= inst_d;
      op_q      <= op_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.op         = op_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit: sequential, back-pressure, redirect, halt, wrap/reset.
module tb_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat = 1;
  int   cnt = 0;
  int   wcnt = 0;

  logic [31:0] mem [256];
  exp_t        exp_q[$];
  logic [7:0]  addr_log[$];
  logic [7:0]  waddr_log[$];

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  fetch_unit_if #(.PC_W(8), .INST_W(32)) b ();
  fetch_unit_if #(.PC_W(8), .INST_W(32)) w ();

  fetch_unit #(.PC_W(8), .INST_W(32), .RESET_PC(8'h00), .HALT_OP(6'd63)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );

  fetch_unit #(.PC_W(8), .INST_W(32), .RESET_PC(8'hFE), .HALT_OP(6'd63)) dut_wrap (
    .clk(clk), .rst(rst2), .bus(w)
  );

  always #5 clk = ~clk;

  // Instruction memory with programmable ack latency, one ack pulse per request.
  always begin
    @(posedge clk);
    #1;
    if (rst || !b.imem_req || b.imem_ack) begin
      b.imem_ack = 1'b0;
      cnt = 0;
    end else begin
      cnt++;
      if (cnt >= lat) begin
        b.imem_ack   = 1'b1;
        b.imem_rdata = mem[b.imem_addr];
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rst2 || !w.imem_req || w.imem_ack) begin
      w.imem_ack = 1'b0;
      wcnt = 0;
    end else begin
      wcnt++;
      w.imem_ack   = 1'b1;
      w.imem_rdata = {24'h0, w.imem_addr};
    end
  end

  function automatic logic [31:0] pack_log(input logic [7:0] q[$]);
    logic [31:0] r;
    r = {8'(q.size()), 24'h0};
    for (int i = 0; i < q.size() && i < 3; i++) r[23-8*i -: 8] = q[i];
    return r;
  endfunction

  // One clock: mid-cycle scoreboard/monitor sampling, then return just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (b.imem_req && b.imem_ack) addr_log.push_back(b.imem_addr);
      if (b.inst_valid && b.inst_ready && !b.redirect) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL accept_extra got pc=%h inst=%h, expected no instruction", b.inst_pc, b.inst);
        end else begin
          e = exp_q.pop_front();
          if (b.inst_pc !== e.pc || b.inst !== e.w || b.op !== e.w[31:26]) begin
            n_err++;
            $display("FAIL accept got pc=%h inst=%h op=%0d, expected pc=%h inst=%h op=%0d",
                     b.inst_pc, b.inst, b.op, e.pc, e.w, e.w[31:26]);
          end
        end
      end
    end
    if (!rst2 && w.imem_req && w.imem_ack) waddr_log.push_back(w.imem_addr);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b.inst_ready = 1'b0;
    b.redirect = 1'b0;
    b.redirect_pc = 8'h00;
    lat = 1;
    exp_q.delete();
    addr_log.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    n_vec++; if (b.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b, expected 0", b.imem_req); end
    n_vec++; if (b.inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b, expected 0", b.inst_valid); end
    n_vec++; if (b.inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h, expected 0", b.inst); end
    n_vec++; if (b.op !== 6'h0) begin n_err++; $display("FAIL rst_op got %h, expected 0", b.op); end
    n_vec++; if (b.inst_pc !== 8'h0) begin n_err++; $display("FAIL rst_inst_pc got %h, expected 0", b.inst_pc); end
    n_vec++; if (b.halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b, expected 0", b.halted); end
    rst = 1'b0;
    tick();
    n_vec++;
    if (b.imem_req !== 1'b1 || b.imem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL rst_first_req got req=%b addr=%h, expected req=1 addr=00", b.imem_req, b.imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0400_0002;
    mem[2] = HALT_W | 32'h2;
    exp_q.push_back('{8'h00, mem[0]});
    exp_q.push_back('{8'h01, mem[1]});
    exp_q.push_back('{8'h02, mem[2]});
    b.inst_ready = 1'b1;
    for (int i = 0; i < 100 && !b.halted; i++) tick();
    n_vec++; if (b.halted !== 1'b1) begin n_err++; $display("FAIL seq_halt got halted=%b, expected 1", b.halted); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq_drain got %0d pending, expected 0", exp_q.size()); end
    n_vec++;
    if (pack_log(addr_log) !== 32'h0300_0102) begin
      n_err++;
      $display("FAIL seq_addrs got %h, expected 03000102", pack_log(addr_log));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem[0] = 32'h0800_1234;
    mem[1] = HALT_W | 32'h1;
    exp_q.push_back('{8'h00, mem[0]});
    exp_q.push_back('{8'h01, mem[1]});
    for (int i = 0; i < 20 && !b.inst_valid; i++) tick();
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (b.inst_valid !== 1'b1 || b.inst !== 32'h0800_1234 || b.op !== 6'd2 ||
          b.inst_pc !== 8'h00 || b.imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got valid=%b inst=%h op=%0d pc=%h req=%b, expected 1 08001234 2 00 0",
                 c, b.inst_valid, b.inst, b.op, b.inst_pc, b.imem_req);
      end
      tick();
    end
    b.inst_ready = 1'b1;
    tick();
    n_vec++;
    if (b.imem_req !== 1'b1 || b.imem_addr !== 8'h01) begin
      n_err++;
      $display("FAIL bp_next got req=%b addr=%h, expected req=1 addr=01", b.imem_req, b.imem_addr);
    end
    for (int i = 0; i < 50 && !b.halted; i++) tick();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain got %0d pending, expected 0", exp_q.size()); end
    n_vec++;
    if (pack_log(addr_log) !== 32'h0200_0100) begin
      n_err++;
      $display("FAIL bp_addrs got %h, expected 02000100", pack_log(addr_log));
    end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    lat = 4;
    mem[0]    = 32'h1400_0BAD;
    mem[8'h40] = 32'h0C00_0040;
    mem[8'h41] = HALT_W | 32'h41;
    exp_q.push_back('{8'h40, mem[8'h40]});
    exp_q.push_back('{8'h41, mem[8'h41]});
    b.inst_ready = 1'b1;
    tick();
    tick();
    b.redirect = 1'b1;
    b.redirect_pc = 8'h40;
    tick();
    b.redirect = 1'b0;
    for (int i = 0; i < 10 && !b.imem_ack; i++) begin
      n_vec++;
      if (b.imem_req !== 1'b1 || b.imem_addr !== 8'h00) begin
        n_err++;
        $display("FAIL drain_hold got req=%b addr=%h, expected req=1 addr=00", b.imem_req, b.imem_addr);
      end
      tick();
    end
    for (int i = 0; i < 100 && !b.halted; i++) tick();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_pending got %0d, expected 0", exp_q.size()); end
    n_vec++;
    if (pack_log(addr_log) !== 32'h0300_4041) begin
      n_err++;
      $display("FAIL drain_addrs got %h, expected 03004041", pack_log(addr_log));
    end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    mem[0]     = 32'h1000_0000;
    mem[8'h10] = 32'h1400_0010;
    mem[8'h11] = HALT_W | 32'h11;
    exp_q.push_back('{8'h10, mem[8'h10]});
    exp_q.push_back('{8'h11, mem[8'h11]});
    for (int i = 0; i < 20 && !b.inst_valid; i++) tick();
    b.inst_ready = 1'b1;
    b.redirect = 1'b1;
    b.redirect_pc = 8'h10;
    tick();
    b.redirect = 1'b0;
    n_vec++;
    if (b.inst_valid !== 1'b0 || b.imem_req !== 1'b1 || b.imem_addr !== 8'h10) begin
      n_err++;
      $display("FAIL flush got valid=%b req=%b addr=%h, expected 0 1 10", b.inst_valid, b.imem_req, b.imem_addr);
    end
    for (int i = 0; i < 50 && !b.halted; i++) tick();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL flush_pending got %0d, expected 0", exp_q.size()); end
    n_vec++;
    if (pack_log(addr_log) !== 32'h0300_1011) begin
      n_err++;
      $display("FAIL flush_addrs got %h, expected 03001011", pack_log(addr_log));
    end
  endtask

  task automatic test_halt();
    do_reset();
    mem[0] = HALT_W;
    mem[5] = HALT_W | 32'h5;
    exp_q.push_back('{8'h00, mem[0]});
    b.inst_ready = 1'b1;
    for (int i = 0; i < 20 && !b.halted; i++) tick();
    for (int c = 0; c < 20; c++) begin
      n_vec++;
      if (b.halted !== 1'b1 || b.imem_req !== 1'b0 || b.inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold cycle %0d got halted=%b req=%b valid=%b, expected 1 0 0",
                 c, b.halted, b.imem_req, b.inst_valid);
      end
      tick();
    end
    exp_q.push_back('{8'h05, mem[5]});
    b.redirect = 1'b1;
    b.redirect_pc = 8'h05;
    tick();
    b.redirect = 1'b0;
    n_vec++;
    if (b.halted !== 1'b0 || b.imem_req !== 1'b1 || b.imem_addr !== 8'h05) begin
      n_err++;
      $display("FAIL halt_exit got halted=%b req=%b addr=%h, expected 0 1 05", b.halted, b.imem_req, b.imem_addr);
    end
    for (int i = 0; i < 20 && !b.halted; i++) tick();
    n_vec++;
    if (pack_log(addr_log) !== 32'h0200_0500 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL halt_addrs got %h pending=%0d, expected 02000500 pending=0", pack_log(addr_log), exp_q.size());
    end
  endtask

  task automatic test_wrap_reset();
    rst = 1'b1;
    w.inst_ready = 1'b1;
    w.redirect = 1'b0;
    w.redirect_pc = 8'h00;
    waddr_log.delete();
    rst2 = 1'b0;
    for (int i = 0; i < 50 && waddr_log.size() < 3; i++) tick();
    n_vec++;
    if (pack_log(waddr_log) !== 32'h03FE_FF00) begin
      n_err++;
      $display("FAIL wrap_addrs got %h, expected 03FEFF00", pack_log(waddr_log));
    end
    for (int i = 0; i < 10 && !w.imem_req; i++) tick();
    rst2 = 1'b1;
    tick();
    tick();
    n_vec++;
    if (w.imem_req !== 1'b0 || w.imem_addr !== 8'h00 || w.inst_valid !== 1'b0 || w.inst !== 32'h0 ||
        w.op !== 6'h0 || w.inst_pc !== 8'h00 || w.halted !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_rst got req=%b addr=%h valid=%b inst=%h op=%h pc=%h halted=%b, expected all 0",
               w.imem_req, w.imem_addr, w.inst_valid, w.inst, w.op, w.inst_pc, w.halted);
    end
    rst2 = 1'b0;
    tick();
    n_vec++;
    if (w.imem_req !== 1'b1 || w.imem_addr !== 8'hFE) begin
      n_err++;
      $display("FAIL wrap_restart got req=%b addr=%h, expected req=1 addr=FE", w.imem_req, w.imem_addr);
    end
    rst2 = 1'b1;
  endtask

  initial begin
    b.imem_ack = 1'b0;
    b.imem_rdata = 32'h0;
    b.inst_ready = 1'b0;
    b.redirect = 1'b0;
    b.redirect_pc = 8'h00;
    w.imem_ack = 1'b0;
    w.imem_rdata = 32'h0;
    w.inst_ready = 1'b0;
    w.redirect = 1'b0;
    w.redirect_pc = 8'h00;
    @(posedge clk);
    #2;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_accept();
    test_halt();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer for the single-issue core. It owns the program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents each word with its 6-bit opcode field to the decode stage over a valid/ready handshake.
- It takes branch redirects back from execute, which closes the loop opened by the opcode decoder's branch outputs.

Parameters:
- PC_W, 8, width of the word-addressed program counter and memory address.
- INST_W, 32, instruction width; opcode is bits [INST_W-1:INST_W-6].
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 6'd63, opcode that stops sequential fetch.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  PC_W  fetch address; stable while imem_req high.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  INST_W  fetched instruction word.
- inst_valid  out  1  instruction held for decode.
- inst_ready  in  1  decode accepts instruction when inst_valid && inst_ready.
- inst  out  INST_W  held instruction word.
- op  out  6  opcode field of inst, registered with inst.
- inst_pc  out  PC_W  address the held instruction was fetched from.
- redirect  in  1  branch taken; single-cycle pulse from execute.
- redirect_pc  in  PC_W  branch target, valid when redirect is high.
- halted  out  1  high while stopped on HALT_OP.

Behaviour:
- Reset (checked at posedge clk with rst=1):
  - pc=RESET_PC; state=FETCH.
  - imem_req=0, inst_valid=0, inst=0, op=0, inst_pc=0, halted=0.
  - imem_req asserts on the first cycle after rst deasserts.
  - Reset mid-handshake abandons the request; a late imem_ack is ignored until a new request is raised.
- States: FETCH, ISSUE, DRAIN, HALT. All outputs are registered.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: inst<=imem_rdata; op<=imem_rdata[INST_W-1:INST_W-6]; inst_pc<=pc; pc<=pc+1 (mod 2^PC_W, so all-ones wraps to 0); inst_valid<=1; imem_req<=0; go to ISSUE.
  - Minimum spacing: ack at cycle N gives inst_valid at N+1, and the next imem_req is no earlier than the cycle after the handshake.
- ISSUE:
  - inst_valid=1; inst, op and inst_pc are held stable.
  - On inst_ready: inst_valid<=0.
    - If op==HALT_OP, go to HALT and set halted<=1.
    - Otherwise go to FETCH, with imem_req rising the next cycle.
  - Decode back-pressure is unlimited.
- HALT:
  - imem_req=0, inst_valid=0, halted=1.
  - Exits only on redirect or rst.
- Redirect (priority over every other event in the same cycle):
  - FETCH with imem_ack low: the request is outstanding and cannot be withdrawn. pc<=redirect_pc; go to DRAIN with imem_req and imem_addr unchanged.
  - FETCH with imem_ack high: returned data is discarded; pc<=redirect_pc; stay in FETCH with the new address next cycle; inst_valid stays 0.
  - ISSUE: inst_valid<=0 (flushed even if inst_ready is high the same cycle; that instruction is not counted as accepted); pc<=redirect_pc; go to FETCH.
  - HALT: halted<=0; pc<=redirect_pc; go to FETCH.
  - DRAIN: pc<=redirect_pc (latest target wins); remain in DRAIN.
- DRAIN:
  - Keep imem_req=1 at the old address until imem_ack.
  - On ack: discard data, imem_req<=0, go to FETCH (new address the following cycle).
- Other rules:
  - No instruction is ever presented twice or skipped except by redirect.
  - The redirect_pc value is used verbatim (no alignment or offset added).

Test Plan:
- Sequential fetch:
  - Stimulus: memory with 1-cycle ack holding words 0x0000_0001 (op 0) and 0x0400_0002 (op 1) at addr 0 and 1; inst_ready=1.
  - Response: inst_pc 0 then 1; op 0 then 1; imem_addr 0,1,2 in order; no duplicates.
- Back-pressure:
  - Stimulus: hold inst_ready=0 for 5 cycles after inst_valid.
  - Response: inst, op and inst_pc stable and imem_req=0 throughout; next fetch address is inst_pc+1 after acceptance.
- Redirect during outstanding fetch:
  - Stimulus: memory ack latency 4; redirect with redirect_pc=8'h40 one cycle after imem_req rises.
  - Response: imem_addr holds the old value until ack; that data is never presented; next imem_addr=0x40; first inst_pc=0x40.
- Redirect colliding with acceptance:
  - Stimulus: redirect and inst_ready both high in ISSUE, redirect_pc=8'h10.
  - Response: inst_valid drops; next fetch address 0x10; the flushed instruction does not reappear.
- Halt:
  - Stimulus: word with op 63 fetched.
  - Response: after acceptance, halted=1 and imem_req stays 0 for 20 cycles; redirect_pc=8'h05 clears halted and fetches addr 5.
- Wrap and reset:
  - Stimulus: PC_W=8, RESET_PC=8'hFE, run 3 fetches, then assert rst while imem_req is high.
  - Response: addresses 0xFE, 0xFF, 0x00; after rst, all outputs are 0 and the next request is at 0xFE.
